lab5_loader: RTL and testbench

Upstream sequencer for the lab5 summation memory. Accepts a frame of bytes over a valid/ready stream and writes them into the memory's consecutive addresses from 0. It then pulses `start`, waits for `done`, and returns `ans` on a result handshake. This replaces the hand-driven `we`/`addr`/`din`/`start` stimulus with a reusable front-end.

---
 rtl/lab5_pkg.sv | 18 +
 rtl/lab5_wait_timer.sv | 31 +++
 rtl/lab5_loader.sv | 168 ++++++++++++++++
 tb/tb_lab5_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab5_pkg.sv
// Shared definitions for the lab5 loader and the summation memory it feeds.
// LOADER_VERIFY_EN adds the VERIFY read-back state to the loader FSM encoding.
package lab5_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
`ifdef LOADER_VERIFY_EN
    ST_VERIFY = 3'd1,
`endif
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/lab5_wait_timer.sv
// Wait-for-done timer: loads on clear, counts down while enabled and saturates at zero.
// expired is high once TIMEOUT enabled cycles have elapsed since the last clear.
module lab5_wait_timer
  import lab5_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Loading TIMEOUT-1 makes the TIMEOUT-th enabled cycle the one that sees zero.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= CW'(TIMEOUT - 1);
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/lab5_loader.sv
// Stream-to-memory loader for the lab5 summation memory: loads a frame, kicks the sum, returns the result.
// Define LOADER_VERIFY_EN to read the frame back and flag mismatches on err before kicking.
//
// state  | meaning
// LOAD   | idle / accepting stream bytes into addresses 0..DEPTH-1
// VERIFY | reading the frame back and comparing to the shadow copy
// KICK   | one-cycle start pulse, wait timer cleared
// WAIT   | waiting for done or timeout
// HOLD   | presenting the result until res_ready
module lab5_loader
  import lab5_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic [DW-1:0] din,
  output logic          re,
  input  logic [DW-1:0] dout,
  output logic          start,
  input  logic          done,
  input  logic [DW-1:0] ans,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          err
);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic          accept;
  logic          last_beat;
  logic          tmr_expired;

  assign in_ready  = (state == ST_LOAD) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (idx == AW'(DEPTH - 1));
  assign start     = (state == ST_KICK);

`ifdef LOADER_VERIFY_EN
  logic [AW:0]   vcnt;
  logic          verify_end;
  logic          chk_valid;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] shadow [2**AW];

  assign verify_end = (vcnt == (AW + 1)'(DEPTH));
`endif

  lab5_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_KICK),
    .en     (state == ST_WAIT),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_LOAD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:
        if (last_beat)
`ifdef LOADER_VERIFY_EN
          state_nxt = ST_VERIFY;
`else
          state_nxt = ST_KICK;
`endif
`ifdef LOADER_VERIFY_EN
      ST_VERIFY:
        if (verify_end) state_nxt = ST_KICK;
`endif
      ST_KICK: state_nxt = ST_WAIT;
      ST_WAIT:
        if (done || tmr_expired) state_nxt = ST_HOLD;
      ST_HOLD:
        if (res_ready) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      addr      <= '0;
      we        <= 1'b0;
      din       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else begin
      we <= 1'b0;
      if (accept) begin
        we   <= 1'b1;
        addr <= idx;
        din  <= in_data;
        idx  <= idx + 1'b1;
        if (idx == '0) err <= 1'b0;
      end
`ifdef LOADER_VERIFY_EN
      if (state == ST_VERIFY && !verify_end) addr <= vcnt[AW-1:0];
      if (chk_valid && dout != shadow[chk_addr]) err <= 1'b1;
`endif
      if (state == ST_WAIT) begin
        if (done) begin
          res_valid <= 1'b1;
          res_data  <= ans;
        end else if (tmr_expired) begin
          res_valid <= 1'b1;
          res_data  <= '0;
          err       <= 1'b1;
        end
      end
      if (state == ST_HOLD && res_ready) begin
        res_valid <= 1'b0;
        idx       <= '0;
      end
    end
  end

`ifdef LOADER_VERIFY_EN
  // Read data returns one cycle after the address, so the compare trails re/addr by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt      <= '0;
      re        <= 1'b0;
      chk_valid <= 1'b0;
      chk_addr  <= '0;
    end else begin
      chk_valid <= re;
      chk_addr  <= addr;
      re        <= 1'b0;
      if (state == ST_LOAD) begin
        vcnt <= '0;
      end else if (state == ST_VERIFY && !verify_end) begin
        re   <= 1'b1;
        vcnt <= vcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) shadow[idx] <= in_data;
  end
`else
  logic unused_dout;

  assign re          = 1'b0;
  assign unused_dout = ^dout;
`endif

endmodule

// File: tb/tb_lab5_loader.sv
// Self-checking bench for lab5_loader: behavioural summation memory plus a frame-level reference model.
// Build with LOADER_VERIFY_EN defined to also exercise the read-back check.
module tb_lab5_loader;

  localparam int DW      = 8;
  localparam int AW      = 3;
  localparam int DEPTH   = 6;
  localparam int TIMEOUT = 15;
`ifdef LOADER_VERIFY_EN
  localparam int LAT = 2 + DEPTH + 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk, rst, in_valid, in_ready, we, re, start, done, res_valid, res_ready, err;
  logic [DW-1:0] in_data, din, dout, ans, res_data;
  logic [AW-1:0] addr;

  lab5_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr(addr), .we(we), .din(din), .re(re), .dout(dout), .start(start), .done(done),
    .ans(ans), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Summation memory model: writes land at the edge, start sums the first DEPTH words.
  logic [7:0] mem [8];
  bit never_done, corrupt;

  always @(posedge clk) begin
    logic [7:0] s;
    if (rst) begin
      done <= 1'b0;
      ans  <= '0;
      dout <= '0;
    end else begin
      if (we) mem[addr] = din;
      done <= 1'b0;
      if (start && !never_done) begin
        s = 8'd0;
        for (int i = 0; i < DEPTH; i++) s = s + mem[i];
        done <= 1'b1;
        ans  <= s;
      end
      if (re) dout <= (corrupt && addr == 3'd2) ? ~mem[addr] : mem[addr];
    end
  end

  // Observers: sampled just after the falling edge.
  int cyc;
  int wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$];
  int start_cnt, rdy_bad, t_start;
  bit busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (we) begin
      wr_addr.push_back(int'(addr));
      wr_data.push_back(int'(din));
      wr_cyc.push_back(cyc);
    end
    if (re) rd_addr.push_back(int'(addr));
    if (start) begin
      start_cnt++;
      t_start = cyc;
    end
    if (busy && in_ready) rdy_bad++;
  end

  logic [7:0] frame [DEPTH];
  int t_last, err_first, wr_base, rd_base, st_base, rb_base;

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input int gap, input bit rnd);
    bit ok;
    int g;
    wr_base = wr_addr.size();
    rd_base = rd_addr.size();
    st_base = start_cnt;
    rb_base = rdy_bad;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(frame[i], ok);
      check("beat_accepted", 32'(ok), 1);
      if (i == 0) err_first = int'(err);
      if (i == DEPTH - 1) begin
        t_last = cyc;
        busy   = 1'b1;
      end else begin
        g = rnd ? int'($urandom_range(0, gap)) : gap;
        repeat (g) @(negedge clk);
      end
    end
  endtask

  task automatic get_result(output int rv_cyc, output logic [7:0] d, output logic e);
    int t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_seen", 32'(res_valid), 1);
    rv_cyc = cyc;
    d      = res_data;
    e      = err;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    busy      = 1'b0;
    check("res_valid_drop", 32'(res_valid), 0);
    check("in_ready_back", 32'(in_ready), 1);
  endtask

  task automatic check_frame_io(input bit consec);
    check("wr_count", wr_addr.size() - wr_base, DEPTH);
    for (int i = 0; i < DEPTH && wr_base + i < wr_addr.size(); i++) begin
      check("wr_addr", wr_addr[wr_base + i], i);
      check("wr_data", wr_data[wr_base + i], int'(frame[i]));
      if (consec && i > 0)
        check("wr_back2back", wr_cyc[wr_base + i] - wr_cyc[wr_base + i - 1], 1);
    end
    check("start_pulses", start_cnt - st_base, 1);
    check("in_ready_busy", rdy_bad - rb_base, 0);
`ifdef LOADER_VERIFY_EN
    check("rd_count", rd_addr.size() - rd_base, DEPTH);
    for (int i = 0; i < DEPTH && rd_base + i < rd_addr.size(); i++)
      check("rd_addr", rd_addr[rd_base + i], i);
`else
    check("re_idle", rd_addr.size() - rd_base, 0);
`endif
  endtask

  task automatic run_frame(input int gap, input bit rnd);
    int rv, exp_sum;
    logic [7:0] d;
    logic e;
    exp_sum = 0;
    for (int i = 0; i < DEPTH; i++) exp_sum += int'(frame[i]);
    send_frame(gap, rnd);
    check("err_clear_first_beat", err_first, 0);
    get_result(rv, d, e);
    check("latency", rv - t_last, LAT);
    check("res_data", d, exp_sum % 256);
    check("err", e, 0);
    check_frame_io(!rnd && gap == 0);
    ack();
  endtask

  task automatic load_ref_frame();
    for (int i = 0; i < DEPTH; i++) frame[i] = 8'(10 * (i + 1));
  endtask

  initial begin
    int rv;
    logic [7:0] d;
    logic e;
    bit ok;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    never_done = 1'b0; corrupt = 1'b0; busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready_after", 32'(in_ready), 1);
    check("rst_addr", 32'(addr), 0);
    check("rst_we", 32'(we), 0);
    check("rst_din", 32'(din), 0);
    check("rst_re", 32'(re), 0);
    check("rst_start", 32'(start), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);

    // Reference frame, continuous and with 2-cycle gaps.
    load_ref_frame();
    run_frame(0, 1'b0);
    run_frame(2, 1'b0);

    // Random frames with random gaps; sums wrap at 8 bits.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) frame[i] = 8'($urandom);
      run_frame(3, 1'b1);
    end

    // No done: timeout after TIMEOUT WAIT cycles, err sticky until the next frame.
    never_done = 1'b1;
    for (int i = 0; i < DEPTH; i++) frame[i] = 8'($urandom);
    send_frame(1, 1'b1);
    get_result(rv, d, e);
    check("timeout_latency", rv - t_start, TIMEOUT + 1);
    check("timeout_res_data", 32'(d), 0);
    check("timeout_err", 32'(e), 1);
    check("timeout_start_pulses", start_cnt - st_base, 1);
    ack();
    never_done = 1'b0;
    repeat (2) @(negedge clk);
    check("err_sticky_idle", 32'(err), 1);
    load_ref_frame();
    run_frame(0, 1'b0);

    // Consumer stalls: result stable, incoming bytes refused.
    load_ref_frame();
    send_frame(0, 1'b0);
    get_result(rv, d, e);
    check("hold_first_data", 32'(d), 210);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      check("hold_res_valid", 32'(res_valid), 1);
      check("hold_res_data", 32'(res_data), 210);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_we", 32'(we), 0);
    end
    in_valid = 1'b0;
    check_frame_io(1'b1);
    ack();

    // Reset after three beats, then a clean frame must start at address 0.
    load_ref_frame();
    for (int i = 0; i < 3; i++) send_byte(frame[i], ok);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_we", 32'(we), 0);
    check("midrst_din", 32'(din), 0);
    check("midrst_addr", 32'(addr), 0);
    run_frame(0, 1'b0);

`ifdef LOADER_VERIFY_EN
    // Corrupted read-back of word 2 flags err but the sum still runs.
    corrupt = 1'b1;
    load_ref_frame();
    send_frame(0, 1'b0);
    get_result(rv, d, e);
    check("verify_err", 32'(e), 1);
    check("verify_res_data", 32'(d), 210);
    check("verify_latency", rv - t_last, LAT);
    check_frame_io(1'b1);
    ack();
    corrupt = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of run, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
